// File: rtl/rsa_byte_sequencer.sv
// Purpose: packs plaintext bytes into 64-bit blocks for rsa_encrypt, drives its start/busy
//          handshake, then serialises the 64-bit cipher back out MSB byte first.
// Latency: the block launches the cycle after its last input byte. The first cipher byte is
//          offered the cycle after busy falls. Abandoned after TIMEOUT_CYCLES in LAUNCH+WAIT.
// Backpressure: in_ready is high only while collecting, so blocks never overlap. out_data is
//          held stable while out_valid && !out_ready.
// Ports:
//   clk, rst                     : clock and synchronous active-high reset
//   in_data/in_valid/in_last     : plaintext byte stream; in_ready accepts it
//   out_data/out_valid/out_ready : cipher byte stream
//   enc_start/enc_plain          : request and operand to rsa_encrypt
//   enc_busy/enc_cipher          : status and result from rsa_encrypt
//   blocks_done, timeout_err     : count of emitted blocks; sticky abandon flag
module rsa_byte_sequencer #(
  parameter int BLOCK_BYTES    = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        enc_start,
  output logic [63:0] enc_plain,
  input  logic        enc_busy,
  input  logic [63:0] enc_cipher,
  output logic [15:0] blocks_done,
  output logic        timeout_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [2:0]    LAST_IDX = 3'(BLOCK_BYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_COLLECT, S_LAUNCH, S_WAIT, S_EMIT} state_t;

  state_t        state, state_nxt;
  logic [2:0]    byte_cnt;
  logic [2:0]    emit_cnt;
  logic [63:0]   pack_q;
  logic [63:0]   plain_q;
  logic [63:0]   shift_q;
  logic [TW-1:0] tmo_cnt;
  logic [15:0]   done_q;
  logic          err_q;

  logic          in_xfer;
  logic          out_xfer;
  logic          block_end;
  logic          tmo_hit;
  logic          in_flight;
  logic          in_flight_nxt;
  logic [63:0]   pack_shift;
  logic [5:0]    pad_bits;
  logic [63:0]   plain_nxt;

  assign in_xfer    = (state == S_COLLECT) && in_valid;
  assign out_xfer   = (state == S_EMIT) && out_ready;
  assign block_end  = in_xfer && (in_last || (byte_cnt == LAST_IDX));
  assign tmo_hit    = (tmo_cnt == TMO_LAST);
  assign pack_shift = {pack_q[55:0], in_data};
  // A short block is left-aligned: the first byte always lands in [63:56].
  assign pad_bits   = {LAST_IDX - byte_cnt, 3'b000};
  assign plain_nxt  = pack_shift << pad_bits;

  assign in_flight     = (state == S_LAUNCH) || (state == S_WAIT);
  assign in_flight_nxt = (state_nxt == S_LAUNCH) || (state_nxt == S_WAIT);

  always_comb begin
    state_nxt = state;
    case (state)
      S_COLLECT: if (block_end) state_nxt = S_LAUNCH;
      // A handshake step arriving in the final allowed cycle still wins over the timeout.
      S_LAUNCH: begin
        if (enc_busy)     state_nxt = S_WAIT;
        else if (tmo_hit) state_nxt = S_COLLECT;
      end
      S_WAIT: begin
        if (!enc_busy)    state_nxt = S_EMIT;
        else if (tmo_hit) state_nxt = S_COLLECT;
      end
      S_EMIT: if (out_xfer && (emit_cnt == 3'd7)) state_nxt = S_COLLECT;
      default: state_nxt = S_COLLECT;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_COLLECT);
    enc_start = (state == S_LAUNCH);
    out_valid = (state == S_EMIT);
    out_data  = shift_q[63:56];
  end

  assign enc_plain   = plain_q;
  assign blocks_done = done_q;
  assign timeout_err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_COLLECT;
      byte_cnt <= '0;
      emit_cnt <= '0;
      pack_q   <= '0;
      plain_q  <= '0;
      shift_q  <= '0;
      tmo_cnt  <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;

      if (block_end) begin
        plain_q  <= plain_nxt;
        pack_q   <= '0;
        byte_cnt <= '0;
      end else if (in_xfer) begin
        pack_q   <= pack_shift;
        byte_cnt <= byte_cnt + 3'd1;
      end

      // The counter spans LAUNCH and WAIT together; any exit restarts it.
      if (in_flight && in_flight_nxt) tmo_cnt <= tmo_cnt + 1'b1;
      else                            tmo_cnt <= '0;

      if (in_flight && (state_nxt == S_COLLECT)) err_q <= 1'b1;

      // The encryptor updates cipher on the same edge busy falls, so it is valid here.
      if ((state == S_WAIT) && !enc_busy) begin
        shift_q  <= enc_cipher;
        emit_cnt <= '0;
      end else if (out_xfer) begin
        shift_q  <= {shift_q[55:0], 8'h00};
        emit_cnt <= emit_cnt + 3'd1;
        if (emit_cnt == 3'd7) done_q <= done_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rsa_byte_sequencer.sv
// Purpose: self-checking bench for rsa_byte_sequencer with a behavioural encryptor alongside it.
// Latency: the encryptor raises busy one cycle after it sees start, and holds it for a set or random count.
// Backpressure: out_ready is driven always-on, toggling or random; input gaps are random.
module tb_rsa_byte_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        enc_start;
  logic [63:0] enc_plain;
  logic        enc_busy;
  logic [63:0] enc_cipher;
  logic [15:0] blocks_done;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  // Encryptor-stub controls: dead never raises busy, kind picks the transform, lat fixes busy length.
  bit          stub_dead = 1'b0;
  bit          kind      = 1'b0;
  int          lat_cfg   = 0;
  int          busy_rises = 0;
  int          remain;
  logic [63:0] held_plain;
  logic [15:0] exp_done = 16'd0;

  always #5 clk = ~clk;

  rsa_byte_sequencer #(.BLOCK_BYTES(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .enc_start(enc_start), .enc_plain(enc_plain), .enc_busy(enc_busy), .enc_cipher(enc_cipher),
    .blocks_done(blocks_done), .timeout_err(timeout_err)
  );

  // kind 0: textbook RSA with n=35, e=5. kind 1: bitwise inverse, which exercises every byte lane.
  function automatic logic [63:0] ref_cipher(input logic [63:0] p, input bit k);
    longint unsigned m, r;
    if (k) return ~p;
    m = p % 64'd35;
    r = 1;
    repeat (5) r = (r * m) % 64'd35;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      enc_busy   <= 1'b0;
      enc_cipher <= '0;
      remain     <= 0;
    end else if (enc_busy) begin
      if (remain <= 1) begin
        enc_busy   <= 1'b0;
        enc_cipher <= ref_cipher(held_plain, kind);
      end else begin
        remain <= remain - 1;
      end
    end else if (enc_start && !stub_dead) begin
      enc_busy   <= 1'b1;
      held_plain <= enc_plain;
      remain     <= (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 6));
      busy_rises <= busy_rises + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents n bytes and returns on the first negedge after the last accept, with in_valid low.
  task automatic feed_bytes(input logic [7:0] b [8], input int n, input bit use_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_last  = 1'($urandom_range(0, 1));  // in_last without in_valid must be ignored
          in_data  = 8'($urandom);
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b[i];
      in_last  = use_last && (i == n - 1);
      check("in_ready_collect", {63'd0, in_ready}, 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_block(input logic [7:0] b [8], input int n, input bit use_last,
                            input int rmode, input bit gaps);
    logic [63:0] ep, ec, got;
    logic [7:0]  held;
    int          starts, k, guard, rises0;
    bit          leak, unstable, dropped, stall_prev;
    ep = '0;
    for (int i = 0; i < n; i++) ep |= 64'(b[i]) << (56 - 8 * i);
    ec     = ref_cipher(ep, kind);
    rises0 = busy_rises;
    feed_bytes(b, n, use_last, gaps);
    check("enc_plain", enc_plain, ep);
    starts = 0; leak = 0; guard = 0;
    while (enc_start === 1'b1 && guard < 100) begin
      starts++;
      leak |= in_ready;
      @(negedge clk);
      guard++;
    end
    check("start_cycles", 64'(starts), 64'd2);
    guard = 0;
    while (out_valid !== 1'b1 && guard < 100) begin
      leak |= in_ready | enc_start;
      @(negedge clk);
      guard++;
    end
    check("out_valid_rise", {63'd0, out_valid}, 64'd1);
    k = 0; guard = 0; got = '0; held = '0;
    unstable = 0; dropped = 0; stall_prev = 0;
    while (k < 8 && guard < 200) begin
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (guard % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid !== 1'b1) dropped = 1;
      if (stall_prev && out_data !== held) unstable = 1;
      leak |= in_ready | enc_start;
      if (out_ready) begin
        got = {got[55:0], out_data};
        k++;
      end
      stall_prev = !out_ready;
      held = out_data;
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    exp_done++;
    check("cipher_bytes", got, ec);
    check("byte_count", 64'(k), 64'd8);
    check("out_stall_stable", {63'd0, unstable}, 64'd0);
    check("out_valid_held", {63'd0, dropped}, 64'd0);
    check("in_ready_blocked", {63'd0, leak}, 64'd0);
    check("busy_handshakes", 64'(busy_rises - rises0), 64'd1);
    check("in_ready_after", {63'd0, in_ready}, 64'd1);
    check("out_valid_after", {63'd0, out_valid}, 64'd0);
    check("blocks_done", 64'(blocks_done), 64'(exp_done));
  endtask

  initial begin
    logic [7:0] blk [8];
    int starts, guard, n;
    bit seen_out;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_enc_start", {63'd0, enc_start}, 64'd0);
    check("rst_enc_plain", enc_plain, 64'd0);
    check("rst_blocks_done", 64'(blocks_done), 64'd0);
    check("rst_timeout_err", {63'd0, timeout_err}, 64'd0);

    // Full block 00*7 02 -> cipher 0x20.
    foreach (blk[i]) blk[i] = 8'h00;
    blk[7] = 8'h02;
    send_block(blk, 8, 1'b0, 0, 1'b0);
    // Full block 00*7 03 with in_last on the 8th byte -> no padding, cipher 0x21.
    blk[7] = 8'h03;
    send_block(blk, 8, 1'b1, 0, 1'b0);
    // Single byte 01 with in_last -> plain 0x0100000000000000, cipher 0x10.
    blk[0] = 8'h01;
    send_block(blk, 1, 1'b1, 0, 1'b0);
    // Distinct cipher bytes with out_ready toggling every cycle.
    kind = 1'b1;
    foreach (blk[i]) blk[i] = 8'(8'h11 * (i + 1));
    send_block(blk, 8, 1'b0, 1, 1'b0);
    // Random lengths, contents, gaps, backpressure and encryptor latency.
    for (int t = 0; t < 12; t++) begin
      kind = 1'($urandom_range(0, 1));
      foreach (blk[i]) blk[i] = 8'($urandom);
      n = $urandom_range(1, 8);
      send_block(blk, n, (n < 8) ? 1'b1 : 1'($urandom_range(0, 1)), 2, 1'b1);
    end

    // Encryptor never answers: abandon after 16 cycles in LAUNCH, emit nothing.
    stub_dead = 1'b1;
    foreach (blk[i]) blk[i] = 8'($urandom);
    feed_bytes(blk, 8, 1'b0, 1'b0);
    starts = 0; guard = 0;
    while (enc_start === 1'b1 && guard < 100) begin
      starts++;
      @(negedge clk);
      guard++;
    end
    check("timeout_start_cycles", 64'(starts), 64'd16);
    check("timeout_err_set", {63'd0, timeout_err}, 64'd1);
    check("timeout_in_ready", {63'd0, in_ready}, 64'd1);
    seen_out = 0;
    repeat (5) begin
      seen_out |= out_valid | enc_start;
      @(negedge clk);
    end
    check("timeout_no_output", {63'd0, seen_out}, 64'd0);
    check("timeout_blocks_done", 64'(blocks_done), 64'(exp_done));
    stub_dead = 1'b0;

    // Reset while waiting on the encryptor, then a clean block.
    kind = 1'b0;
    lat_cfg = 6;
    foreach (blk[i]) blk[i] = 8'h00;
    blk[7] = 8'h04;
    feed_bytes(blk, 8, 1'b0, 1'b0);
    guard = 0;
    while (enc_start === 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("in_wait_before_rst", {62'd0, enc_busy, out_valid}, 64'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_enc_start", {63'd0, enc_start}, 64'd0);
    check("mid_rst_enc_plain", enc_plain, 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_timeout_err", {63'd0, timeout_err}, 64'd0);
    check("mid_rst_blocks_done", 64'(blocks_done), 64'd0);
    exp_done = 16'd0;
    lat_cfg = 0;
    blk[7] = 8'h02;
    send_block(blk, 8, 1'b0, 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
